// File: rtl/vid_pkg.sv
// Shared state encoding and command-source tags for the video fetch scheduler.
package vid_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_VCMD, ST_VWAIT, ST_HCMD, ST_HWAIT} state_t;

    localparam logic MEM_SRC_VID  = 1'b0;
    localparam logic MEM_SRC_HOST = 1'b1;

    function automatic int nbursts(input int line_words, input int burst);
        return line_words / burst;
    endfunction
endpackage

// File: rtl/vid_fetch_addr.sv
// Line start address, in-line offset and remaining-burst counter; reloads on a line trigger, advances per video burst.
module vid_fetch_addr
    import vid_pkg::*;
#(
    parameter int AW         = 20,
    parameter int LINE_WORDS = 160,
    parameter int BURST      = 32,
    parameter int BASE_ADDR  = 0,
    localparam int NB        = nbursts(LINE_WORDS, BURST),
    localparam int CW        = $clog2(NB + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic          v_last,
    input  logic          adv,
    output logic [AW-1:0] line_nxt,
    output logic [AW-1:0] off_nxt,
    output logic [CW-1:0] burst_cnt
);
    logic [AW-1:0] line_addr;
    logic [AW-1:0] off;
    logic [CW-1:0] cnt_nxt;
    logic          first;

    // The first trigger after reset fetches line 0 itself rather than advancing past it.
    always_comb begin
        line_nxt = line_addr;
        off_nxt  = off;
        cnt_nxt  = burst_cnt;
        if (trig) begin
            line_nxt = (v_last || first) ? AW'(BASE_ADDR) : line_addr + AW'(LINE_WORDS);
            off_nxt  = '0;
            cnt_nxt  = CW'(NB);
        end else if (adv) begin
            off_nxt = off + AW'(BURST);
            cnt_nxt = burst_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr <= AW'(BASE_ADDR);
            off       <= '0;
            burst_cnt <= '0;
            first     <= 1'b1;
        end else begin
            line_addr <= line_nxt;
            off       <= off_nxt;
            burst_cnt <= cnt_nxt;
            if (trig) first <= 1'b0;
        end
    end
endmodule

// File: rtl/vid_fetch_sched.sv
// Shares one memory command port: video line prefetch first, host in the gaps; command one cycle after trigger, held until mem_ready.
// Optional statistics outputs are enabled by defining VID_FETCH_SCHED_STATS_EN.
module vid_fetch_sched
    import vid_pkg::*;
#(
    parameter int AW         = 20,
    parameter int LINE_WORDS = 160,
    parameter int BURST      = 32,
    parameter int BASE_ADDR  = 0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_active,
    input  logic          vid_h_last,
    input  logic          vid_v_last,
    output logic          vid_bank,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_len,
    output logic          mem_we,
    output logic          mem_src,
    input  logic          mem_done,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    output logic          host_done,
    output logic          underrun
`ifdef VID_FETCH_SCHED_STATS_EN
    ,
    output logic [15:0]   stat_underruns,
    output logic [15:0]   stat_host_wait
`endif
);
    localparam int CW = $clog2(nbursts(LINE_WORDS, BURST) + 1);

    state_t        state, state_nxt;
    logic          trig, adv, vid_pend, stale, last_ok;
    logic [AW-1:0] line_nxt, off_nxt, cmd_addr, h_addr;
    logic          h_we;
    logic [CW-1:0] burst_cnt;

    vid_fetch_addr #(
        .AW(AW), .LINE_WORDS(LINE_WORDS), .BURST(BURST), .BASE_ADDR(BASE_ADDR)
    ) u_addr (
        .clk(clk), .rst(rst), .trig(trig), .v_last(vid_v_last), .adv(adv),
        .line_nxt(line_nxt), .off_nxt(off_nxt), .burst_cnt(burst_cnt)
    );

    assign trig     = vid_active & vid_h_last;
    assign last_ok  = (state == ST_VWAIT) & mem_done & ~stale & (burst_cnt == CW'(1));
    assign underrun = trig & vid_pend & ~last_ok;
    assign mem_addr = (state == ST_HCMD) ? h_addr : cmd_addr;

    always_comb begin
        state_nxt  = state;
        mem_valid  = 1'b0;
        mem_src    = MEM_SRC_VID;
        mem_we     = 1'b0;
        mem_len    = 8'd0;
        host_ready = 1'b0;
        host_done  = 1'b0;
        adv        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vid_pend || trig) begin
                    state_nxt = ST_VCMD;
                end else if (host_valid && !rst) begin
                    host_ready = 1'b1;
                    state_nxt  = ST_HCMD;
                end
            end
            ST_VCMD: begin
                mem_valid = 1'b1;
                mem_len   = 8'(BURST - 1);
                if (mem_ready) state_nxt = ST_VWAIT;
            end
            ST_VWAIT: begin
                // A burst belonging to a superseded line completes but does not advance the counters.
                if (mem_done) begin
                    adv       = ~stale & ~trig;
                    state_nxt = (!stale && !trig && burst_cnt != CW'(1)) ? ST_VCMD : ST_IDLE;
                end
            end
            ST_HCMD: begin
                mem_valid = 1'b1;
                mem_src   = MEM_SRC_HOST;
                mem_we    = h_we;
                if (mem_ready) state_nxt = ST_HWAIT;
            end
            ST_HWAIT: begin
                if (mem_done) begin
                    host_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            vid_pend <= 1'b0;
            stale    <= 1'b0;
            vid_bank <= 1'b0;
            cmd_addr <= AW'(BASE_ADDR);
            h_addr   <= '0;
            h_we     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (trig)                                vid_pend <= 1'b1;
            else if (adv && burst_cnt == CW'(1))     vid_pend <= 1'b0;
            if (trig) vid_bank <= ~vid_bank;
            if (state == ST_VWAIT && mem_done)       stale <= 1'b0;
            else if (trig && (state == ST_VCMD || state == ST_VWAIT)) stale <= 1'b1;
            // Address is captured on entry so it stays stable even if a new line triggers mid-handshake.
            if (state_nxt == ST_VCMD && state != ST_VCMD) cmd_addr <= line_nxt + off_nxt;
            if (host_ready) begin
                h_addr <= host_addr;
                h_we   <= host_we;
            end
        end
    end

`ifdef VID_FETCH_SCHED_STATS_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_underruns <= '0;
            stat_host_wait <= '0;
            wait_cnt       <= '0;
        end else begin
            if (underrun && stat_underruns != 16'hFFFF) stat_underruns <= stat_underruns + 16'd1;
            if (host_valid && !host_ready) begin
                if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (host_ready && wait_cnt > stat_host_wait) stat_host_wait <= wait_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_vid_fetch_sched.sv
// Directed bench for vid_fetch_sched with an expected-command queue built from line/burst arithmetic.
module tb_vid_fetch_sched;
    localparam int AW = 20, LW = 160, BU = 32, BASE = 0, NB = LW / BU;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          src;
        logic          we;
    } cmd_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          vid_active = 1'b0, vid_h_last = 1'b0, vid_v_last = 1'b0;
    logic          vid_bank, mem_valid, mem_we, mem_src, host_ready, host_done, underrun;
    logic          mem_ready = 1'b1, mem_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_len;
    logic          host_valid = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;

    int   n_test = 0, n_fail = 0;
    int   acc_count = 0, mdone_count = 0, vdone_count = 0, hdone_count = 0, under_count = 0;
    int   done_cnt = 0, resp_seen = 0;
    bit   hold_done = 1'b0;
    cmd_t exp_q[$];
    logic [AW-1:0] mline = '0;
    bit   mfirst = 1'b1;

    vid_fetch_sched dut (
        .clk(clk), .rst(rst), .vid_active(vid_active), .vid_h_last(vid_h_last),
        .vid_v_last(vid_v_last), .vid_bank(vid_bank), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_len(mem_len), .mem_we(mem_we),
        .mem_src(mem_src), .mem_done(mem_done), .host_valid(host_valid),
        .host_ready(host_ready), .host_addr(host_addr), .host_we(host_we),
        .host_done(host_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_test++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Model: a line starts at BASE on the first trigger or frame end, else 160 words past the previous line.
    task automatic new_line(input bit vl, input int nb);
        int nxt;
        nxt = (int'(mline) + LW) % (1 << AW);
        mline  = (mfirst || vl) ? AW'(BASE) : AW'(nxt);
        mfirst = 1'b0;
        for (int k = 0; k < nb; k++)
            exp_q.push_back('{addr: AW'(int'(mline) + k * BU), len: 8'(BU - 1), src: 1'b0, we: 1'b0});
    endtask

    task automatic push_host(input logic [AW-1:0] a, input logic w);
        exp_q.push_back('{addr: a, len: 8'd0, src: 1'b1, we: w});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_t(input bit vl);
        vid_h_last = 1'b1;
        vid_v_last = vl;
        tick(1);
        vid_h_last = 1'b0;
        vid_v_last = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && acc_count == mdone_count && !mem_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_acc(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (acc_count >= target) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("accept_seen", ok, 1);
    endtask

    task automatic wait_hready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (host_ready) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk(name, ok, 1);
    endtask

    // Memory responder: one mem_done pulse a few cycles after each accepted command.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            if (rst) begin
                done_cnt  = 0;
                resp_seen = acc_count;
            end else begin
                if (done_cnt > 0 && !hold_done) begin
                    done_cnt--;
                    if (done_cnt == 0) mem_done = 1'b1;
                end
                if (acc_count != resp_seen) begin
                    resp_seen = acc_count;
                    done_cnt  = 4;
                end
            end
        end
    end

    // Compare process: every accepted command against the model queue, plus held-command stability.
    initial begin
        bit   prev_stall = 1'b0;
        bit   last_src = 1'b0;
        cmd_t prev_cmd, act, want;
        forever begin
            @(negedge clk);
            act = '{addr: mem_addr, len: mem_len, src: mem_src, we: mem_we};
            if (rst) begin
                prev_stall  = 1'b0;
                mdone_count = acc_count;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", mem_valid, 1);
                    chk("stall_cmd", act, prev_cmd);
                end
                if (mem_done) begin
                    mdone_count++;
                    if (!last_src) vdone_count++;
                end
                if (mem_valid && mem_ready) begin
                    acc_count++;
                    last_src = mem_src;
                    if (exp_q.size() == 0) begin
                        chk("cmd_unexpected", act, '0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("cmd", act, want);
                    end
                end
                if (underrun)  under_count++;
                if (host_done) hdone_count++;
                prev_stall = mem_valid && !mem_ready;
                prev_cmd   = act;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vb, hb, ub, base;
        tick(3);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_host_done", host_done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_vid_bank", vid_bank, 0);
        rst = 1'b0;
        vid_active = 1'b1;
        tick(2);

        new_line(0, NB);
        pulse_t(0);
        chk("latency_valid", mem_valid, 1);
        chk("line0_addr", mem_addr, 0);
        chk("line0_bank", vid_bank, 1);
        wait_quiet("drain_line0");

        new_line(0, NB);
        pulse_t(0);
        chk("line1_addr", mem_addr, 160);
        chk("line1_bank", vid_bank, 0);
        wait_quiet("drain_line1");

        new_line(1, NB);
        pulse_t(1);
        chk("wrap_addr", mem_addr, BASE);
        wait_quiet("drain_wrap");
        chk("no_underrun", under_count, 0);

        vb = vdone_count;
        hb = hdone_count;
        new_line(0, NB);
        push_host(20'hABCDE, 1'b1);
        pulse_t(0);
        chk("host_line_addr", mem_addr, 160);
        host_valid = 1'b1;
        host_addr  = 20'hABCDE;
        host_we    = 1'b1;
        wait_hready("host_ready_seen");
        chk("hready_after_5_dones", vdone_count - vb, 5);
        tick(1);
        chk("host_ready_one_cycle", host_ready, 0);
        host_valid = 1'b0;
        host_we    = 1'b0;
        wait_quiet("drain_host");
        chk("host_done_count", hdone_count - hb, 1);

        new_line(0, NB);
        push_host(20'h12345, 1'b0);
        host_valid = 1'b1;
        host_addr  = 20'h12345;
        vid_h_last = 1'b1;
        #1;
        chk("tie_host_ready", host_ready, 0);
        tick(1);
        vid_h_last = 1'b0;
        chk("tie_video_first", {mem_valid, mem_src, mem_addr}, {1'b1, 1'b0, 20'd320});
        wait_hready("tie_host_ready_later");
        tick(1);
        host_valid = 1'b0;
        wait_quiet("drain_tie");

        ub   = under_count;
        base = acc_count;
        new_line(0, 3);
        pulse_t(0);
        wait_acc(base + 3);
        hold_done = 1'b1;
        tick(3);
        new_line(0, NB);
        vid_h_last = 1'b1;
        #1;
        chk("underrun_pulse", underrun, 1);
        tick(1);
        vid_h_last = 1'b0;
        #1;
        chk("underrun_one_cycle", underrun, 0);
        hold_done = 1'b0;
        wait_quiet("drain_underrun");
        chk("underrun_count", under_count - ub, 1);

        mem_ready = 1'b0;
        new_line(0, NB);
        pulse_t(0);
        tick(10);
        chk("stall_hold_valid", mem_valid, 1);
        chk("stall_hold_addr", mem_addr, 800);
        mem_ready = 1'b1;
        wait_quiet("drain_stall");

        base = acc_count;
        new_line(0, 1);
        pulse_t(0);
        wait_acc(base + 1);
        tick(2);
        rst = 1'b1;
        #1;
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_host_ready", host_ready, 0);
        chk("arst_host_done", host_done, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_vid_bank", vid_bank, 0);
        tick(2);
        rst = 1'b0;
        mfirst = 1'b1;
        tick(1);
        new_line(0, NB);
        pulse_t(0);
        chk("post_reset_addr", mem_addr, BASE);
        wait_quiet("drain_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule

// File: doc/vid_fetch_sched.md
Name: vid_fetch_sched

Overview:
- Scheduler sharing one memory command port between the video line fetcher and a host requester.
- Tracks video timing strobes and issues burst commands that prefetch pixel line N+1 into a ping-pong line buffer while line N is displayed.
- Video always has priority; the host is serviced only in the gaps between video bursts.
- Sits between the video timing generator and the memory controller.

Parameters:
- AW, 20, memory word address width
- LINE_WORDS, 160, memory words per video line (multiple of BURST)
- BURST, 32, words per video burst command (power of 2, max 256)
- BASE_ADDR, 0, word address of line 0 of the frame

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-high reset
- vid_active  in  1  active-video qualifier from timing generator
- vid_h_last  in  1  last pixel of line strobe
- vid_v_last  in  1  last line of frame strobe
- vid_bank  out  1  line buffer bank being filled; display reads ~vid_bank
- mem_valid  out  1  command valid
- mem_ready  in  1  command accepted
- mem_addr  out  AW  command word address
- mem_len  out  8  burst length minus 1
- mem_we  out  1  1 = write command (host only)
- mem_src  out  1  0 = video, 1 = host; tags returned data routing
- mem_done  in  1  one-cycle pulse when current command's burst has completed
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted
- host_addr  in  AW  host word address
- host_we  in  1  host write
- host_done  out  1  host command completed (mem_done while host owns the port)
- underrun  out  1  one-cycle pulse: new line trigger with the previous fetch incomplete

Behaviour:
- Reset (async): state IDLE, mem_valid=0, host_ready=0, host_done=0, underrun=0, vid_bank=0, line_addr=BASE_ADDR, burst_cnt=0, vid_pend=0.
- Trigger:
  - T = vid_active & vid_h_last.
  - On T: vid_pend=1, burst_cnt=LINE_WORDS/BURST, vid_bank toggles, off=0.
  - line_addr becomes BASE_ADDR if vid_v_last, else line_addr+LINE_WORDS (AW-bit wrap).
  - line_addr always holds the start address of the line being fetched; the very first fetch after reset starts at the first T.
- FSM states: IDLE, VCMD, VWAIT, HCMD, HWAIT.
  - IDLE: vid_pend goes to VCMD; else host_valid goes to HCMD with host_ready=1 for exactly one cycle, latching addr/we. Video wins a same-cycle tie.
  - VCMD: mem_valid=1, mem_src=0, mem_we=0, mem_addr=line_addr+off, mem_len=BURST-1. Command fields are held stable until mem_ready. On mem_valid&mem_ready go to VWAIT.
  - VWAIT: on mem_done, burst_cnt-1 and off+BURST; go to VCMD if burst_cnt≠1 and no new T has occurred, else IDLE. vid_pend clears when the last burst is done.
  - HCMD: mem_valid=1, mem_src=1, mem_len=0, latched addr/we. On accept go to HWAIT.
  - HWAIT: on mem_done, host_done=1 for 1 cycle, go to IDLE.
- Command latency: the cycle after T, mem_valid rises (from IDLE). A burst is never aborted once issued.
- Underrun:
  - T while vid_pend=1 pulses underrun and restarts the fetch for the new line (counters reloaded).
  - An in-flight video or host command still completes first; the remaining bursts of the old line are dropped.
  - Host starvation is acceptable by design; video needs LINE_WORDS/BURST bursts per line only.
- mem_done outside VWAIT/HWAIT is ignored.

Optional Feature:
- VID_FETCH_SCHED_STATS_EN:
  - Adds output stat_underruns[15:0], a saturating count of underrun pulses, and stat_host_wait[15:0], the maximum cycles any host_valid waited for host_ready (saturating).
  - Both clear on rst only.
- Without the macro these ports and their counters do not exist.

Decomposition:
- Shared package vid_pkg: state encoding localparams (ST_IDLE..ST_HWAIT), MEM_SRC_VID=0, MEM_SRC_HOST=1.
- Optional sub-module vid_fetch_addr: line_addr/off/burst_cnt generator (trigger, advance, frame wrap). The FSM and arbitration stay in the top.

Test Plan:
- Reset, mem_ready=1, mem_done 4 cycles after each accept, 2 lines at LINE_WORDS=160/BURST=32 -> 5 cmds per line at addrs 0,32,64,96,128 then 160..288; vid_bank 1 then 0.
- Assert vid_v_last with T -> next fetch starts at BASE_ADDR; no underrun.
- host_valid held during a video fetch -> host_ready only after the 5th video mem_done; host_done after its mem_done; mem_src=1 for that command.
- host_valid and T in the same IDLE cycle -> video command issued first, host_ready=0 that cycle.
- mem_done withheld; second T after burst 2 -> underrun pulse 1 cycle; after the in-flight done, next cmd addr = new line_addr+0.
- mem_ready held low 10 cycles -> mem_valid, mem_addr and mem_len stable throughout; async rst mid-VWAIT -> all outputs at reset values immediately.
